// File: rtl/bus_dp_pkg.sv
// Shared encodings for the bus datapath: ALU operation codes and control FSM states.
package bus_dp_pkg;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpAnd  = 3'd2,
    OpOr   = 3'd3,
    OpShl  = 3'd4,
    OpShr  = 3'd5,
    OpMul  = 3'd6,
    OpMovi = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StTA   = 3'd1,
    StTB   = 3'd2,
    StTW   = 3'd3,
    StTW2  = 3'd4,
    StDone = 3'd5
  } state_e;

endpackage

// File: rtl/bus_dp_alu.sv
// Combinational ALU: evaluates Y op C into a double-width Z (z_hi, z_lo).
module bus_dp_alu
  import bus_dp_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] c,
  input  op_e               op,
  output logic [DATA_W-1:0] z_hi,
  output logic [DATA_W-1:0] z_lo
);

  localparam int unsigned SW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [SW-1:0]         w_shamt;
  logic [2*DATA_W-1:0]   w_prod;

  assign w_shamt = c[SW-1:0];
  assign w_prod  = {{DATA_W{1'b0}}, y} * {{DATA_W{1'b0}}, c};

  always_comb begin
    z_hi = '0;
    z_lo = '0;
    case (op)
      OpAdd:   z_lo = y + c;
      OpSub:   z_lo = y - c;
      OpAnd:   z_lo = y & c;
      OpOr:    z_lo = y | c;
      OpShl:   z_lo = y << w_shamt;
      OpShr:   z_lo = y >> w_shamt;
      OpMul:   {z_hi, z_lo} = w_prod;
      OpMovi:  z_lo = c;
      default: z_lo = '0;
    endcase
  end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus style sequenced datapath: register file, Y/Z/HI/LO staging and a
// multi-cycle control FSM that executes one operation per start request.
module bus_datapath_seq
  import bus_dp_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NREGS   = 16,
  parameter bit          R0_ZERO = 1'b1,
  localparam int unsigned RW     = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [RW-1:0]     ra,
  input  logic [RW-1:0]     rb,
  input  logic [RW-1:0]     rc,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  input  logic [RW-1:0]     rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  state_e              r_state;
  state_e              w_state_next;

  logic [DATA_W-1:0]   r_regs [NREGS];
  logic [DATA_W-1:0]   r_y;
  logic [DATA_W-1:0]   r_zhi;
  logic [DATA_W-1:0]   r_zlo;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

  op_e                 r_op;
  logic [RW-1:0]       r_ra;
  logic [RW-1:0]       r_rb;
  logic [RW-1:0]       r_rc;
  logic                r_imm_sel;
  logic [DATA_W-1:0]   r_imm;

  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_c;
  logic [DATA_W-1:0]   w_zhi;
  logic [DATA_W-1:0]   w_zlo;

  // R0 reads as zero only on the B path; the C path always sees the stored value.
  assign w_b = (R0_ZERO && (r_rb == '0)) ? '0 : r_regs[r_rb];
  assign w_c = r_imm_sel ? r_imm : r_regs[r_rc];

  bus_dp_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .y    (r_y),
    .c    (w_c),
    .op   (r_op),
    .z_hi (w_zhi),
    .z_lo (w_zlo)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (start) w_state_next = StTA;
      end
      StTA:    w_state_next = StTB;
      StTB:    w_state_next = StTW;
      StTW:    w_state_next = (r_op == OpMul) ? StTW2 : StDone;
      StTW2:   w_state_next = StDone;
      StDone: begin
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_y       <= '0;
      r_zhi     <= '0;
      r_zlo     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_op      <= OpAdd;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rc      <= '0;
      r_imm_sel <= 1'b0;
      r_imm     <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_op      <= op_e'(op);
            r_ra      <= ra;
            r_rb      <= rb;
            r_rc      <= rc;
            r_imm_sel <= imm_sel;
            r_imm     <= imm;
          end
        end
        StTA: r_y <= w_b;
        StTB: begin
          r_zhi <= w_zhi;
          r_zlo <= w_zlo;
        end
        StTW: begin
          if (r_op == OpMul) r_lo <= r_zlo;
          else               r_regs[r_ra] <= r_zlo;
        end
        StTW2: r_hi <= r_zhi;
        default: ;
      endcase
    end
  end

  assign rd_data = r_regs[rd_sel];
  assign hi_out  = r_hi;
  assign lo_out  = r_lo;

endmodule
